memwb_elastic_reg: RTL and testbench
====================================

MEMWB_ELASTIC_REG -- requirements
Module: memwb_elastic_reg

Interface
REQ-001 SHALL have parameter XLEN, 32, data path width of ALU result, load data and PC+4.
REQ-002 SHALL have parameter REG_AW, 5, destination register address width.
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush_i  in  1  synchronous kill of all held entries.
REQ-006 SHALL have port m_valid_i  in  1  MEM-side payload valid.
REQ-007 SHALL have port m_ready_o  out  1  stage can accept a MEM-side payload.
REQ-008 SHALL have ports m_alu_result_i, m_rdata_i, m_pc4_i  in  XLEN each  MEM-side payload words.
REQ-009 SHALL have ports m_rd_i  in  REG_AW, m_regwrite_i  in  1, m_result_src_i  in  2  MEM-side control payload.
REQ-010 SHALL have ports w_valid_o  out  1, w_ready_i  in  1  WB-side handshake.
REQ-011 SHALL have ports w_result_o  out  XLEN, w_rd_o  out  REG_AW, w_regwrite_o  out  1  WB-side payload.

Function
REQ-012 SHALL accept a payload on a cycle with m_valid_i && m_ready_o, and retire one on a cycle with w_valid_o && w_ready_i.
REQ-013 SHALL present an accepted payload on w_* exactly 1 cycle after acceptance when the stage was empty.
REQ-014 SHALL select w_result_o from the head entry: result_src 00 ALU, 01 rdata, 10 pc4, 11 ALU.
REQ-015 SHALL force w_regwrite_o to 0 whenever w_rd_o == 0 or w_valid_o == 0.
REQ-016 SHALL hold all w_* outputs stable while w_valid_o && !w_ready_i.
REQ-017 SHALL retire entries strictly in acceptance order; no drop or duplication except under flush_i.
REQ-018 SHALL, on flush_i high, invalidate every held entry at the next edge and discard any simultaneous acceptance; flush wins over accept and retire.
REQ-019 SHALL sustain one accept and one retire per cycle when w_ready_i is held high.
REQ-020 SHALL treat the ALU, rdata and pc4 words as opaque, with no width conversion; they SHALL be stored as XLEN bits.

Reset
REQ-021 SHALL, while reset is high, drive w_valid_o=0, w_regwrite_o=0, w_result_o=0 and w_rd_o=0, and clear all entries.
REQ-022 SHALL drive m_ready_o=1 from the first edge after reset deasserts; assertion mid-transfer SHALL discard all payloads.

Configuration
REQ-023 SHALL use macro MEMWB_SKID_EN to select the buffering mode.
REQ-024 With MEMWB_SKID_EN defined, SHALL implement a 2-entry skid buffer with states EMPTY, ONE and FULL.
- EMPTY->ONE on accept.
- ONE->FULL on accept without retire.
- FULL->ONE on retire.
- ONE->EMPTY on retire without accept.
- m_ready_o SHALL be a registered signal equal to (state != FULL), with no combinational path from w_ready_i.
REQ-025 Without MEMWB_SKID_EN, SHALL implement a single entry with m_ready_o = !w_valid_o || w_ready_i (combinational).

Structure
REQ-026 SHALL take from shared package memwb_pkg:
- result_src_e (ALU, MEM, PC4)
- packed struct memwb_payload_t {alu, rdata, pc4, rd, regwrite, result_src}
- default constants XLEN_DEF=32, REG_AW_DEF=5
REQ-027 SHALL place the skid storage and state machine in sub-module memwb_skid_buf, instantiated only when MEMWB_SKID_EN is defined.

Verification
REQ-028 Reset then accept {alu=0x10, src=00, rd=3, regwrite=1} with w_ready_i=1 -> the next cycle shows w_valid_o=1, w_result_o=0x10, w_rd_o=3, w_regwrite_o=1.
REQ-029 Accept {rdata=0xDEADBEEF, src=01, rd=0, regwrite=1} -> w_result_o=0xDEADBEEF, w_regwrite_o=0.
REQ-030 Skid mode, w_ready_i=0, offer A=1 and B=2 on back-to-back cycles -> both accepted, m_ready_o=0 on the third cycle; raise w_ready_i -> retires 1 then 2, then m_ready_o=1.
REQ-031 FULL state with flush_i=1 and m_valid_i=1 on the same cycle -> the next cycle shows w_valid_o=0, state EMPTY, and the offered payload never appears.
REQ-032 Stream 0..99 with w_ready_i=1 -> 100 retires in 101 cycles, in order.
REQ-033 Assert reset asynchronously mid-cycle while ONE -> w_valid_o falls before the next clk edge, and all outputs read 0.

Source files
------------

// File: rtl/memwb_pkg.sv
// Shared MEM/WB stage types: result-source encoding, default widths and the
// default-width payload record carried through the stage.
package memwb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  // Encoding 2'b11 is legal on the wire and decodes as ALU.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0]   alu;
    logic [XLEN_DEF-1:0]   rdata;
    logic [XLEN_DEF-1:0]   pc4;
    logic [REG_AW_DEF-1:0] rd;
    logic                  regwrite;
    logic [1:0]            result_src;
  } memwb_payload_t;

endpackage

// File: rtl/memwb_skid_buf.sv
// Two-entry skid buffer (EMPTY/ONE/FULL) holding MEM/WB payloads; the upstream
// ready is registered so it never depends combinationally on i_ready.
module memwb_skid_buf
  import memwb_pkg::*;
#(
  parameter type payload_t = memwb_payload_t
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_flush,
  input  logic     i_valid,
  output logic     o_ready,
  input  payload_t i_data,
  output logic     o_valid,
  input  logic     i_ready,
  output payload_t o_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e   r_state;
  state_e   w_state_next;
  logic     r_ready;
  payload_t r_head;
  payload_t r_skid;

  logic w_accept;
  logic w_retire;
  logic w_load_head;
  logic w_head_from_skid;
  logic w_load_skid;

  assign w_accept = i_valid && r_ready;
  assign w_retire = (r_state != EMPTY) && i_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next != FULL);
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next     = r_state;
    w_load_head      = 1'b0;
    w_head_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_next = ONE;
          w_load_head  = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_retire) begin
          w_load_head = 1'b1;
        end else if (w_accept) begin
          w_state_next = FULL;
          w_load_skid  = 1'b1;
        end else if (w_retire) begin
          w_state_next = EMPTY;
        end
      end
      FULL: begin
        if (w_retire) begin
          w_state_next     = ONE;
          w_load_head      = 1'b1;
          w_head_from_skid = 1'b1;
        end
      end
      default: w_state_next = EMPTY;
    endcase
    if (i_flush) begin
      w_state_next = EMPTY;
      w_load_head  = 1'b0;
      w_load_skid  = 1'b0;
    end
  end

  // NOTE: payload storage is reset as well, because the outputs must read zero
  // while reset is held; storage that may power up as X normally is not reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head) r_head <= w_head_from_skid ? r_skid : i_data;
      if (w_load_skid) r_skid <= i_data;
    end
  end

  assign o_ready = r_ready;
  assign o_valid = (r_state != EMPTY);
  assign o_data  = r_head;

endmodule

// File: rtl/memwb_elastic_reg.sv
// MEM/WB elastic pipeline register with valid/ready on both sides.
// Define MEMWB_SKID_EN for the 2-entry skid buffer; default is a single entry.
module memwb_elastic_reg
  import memwb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              m_valid_i,
  output logic              m_ready_o,
  input  logic [XLEN-1:0]   m_alu_result_i,
  input  logic [XLEN-1:0]   m_rdata_i,
  input  logic [XLEN-1:0]   m_pc4_i,
  input  logic [REG_AW-1:0] m_rd_i,
  input  logic              m_regwrite_i,
  input  logic [1:0]        m_result_src_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [XLEN-1:0]   w_result_o,
  output logic [REG_AW-1:0] w_rd_o,
  output logic              w_regwrite_o
);

  // Same layout as memwb_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rdata;
    logic [XLEN-1:0]   pc4;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic [1:0]        result_src;
  } payload_t;

  payload_t w_in;
  payload_t w_head;
  logic     w_head_valid;

  assign w_in = '{alu:        m_alu_result_i,
                  rdata:      m_rdata_i,
                  pc4:        m_pc4_i,
                  rd:         m_rd_i,
                  regwrite:   m_regwrite_i,
                  result_src: m_result_src_i};

`ifdef MEMWB_SKID_EN
  memwb_skid_buf #(
    .payload_t (payload_t)
  ) u_skid_buf (
    .clk     (clk),
    .reset   (reset),
    .i_flush (flush_i),
    .i_valid (m_valid_i),
    .o_ready (m_ready_o),
    .i_data  (w_in),
    .o_valid (w_head_valid),
    .i_ready (w_ready_i),
    .o_data  (w_head)
  );
`else
  logic     r_valid;
  payload_t r_entry;
  logic     w_accept;
  logic     w_retire;

  assign m_ready_o = !r_valid || w_ready_i;
  assign w_accept  = m_valid_i && m_ready_o;
  assign w_retire  = r_valid && w_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_entry <= w_in;
    end else if (w_retire) begin
      r_valid <= 1'b0;
    end
  end

  assign w_head_valid = r_valid;
  assign w_head       = r_entry;
`endif

  always_comb begin
    w_result_o = w_head.alu;
    case (w_head.result_src)
      RES_MEM: w_result_o = w_head.rdata;
      RES_PC4: w_result_o = w_head.pc4;
      default: w_result_o = w_head.alu;
    endcase
  end

  assign w_valid_o    = w_head_valid;
  assign w_rd_o       = w_head.rd;
  assign w_regwrite_o = w_head_valid && w_head.regwrite && (w_head.rd != '0);

endmodule

// File: tb/tb_memwb_elastic_reg.sv
// Directed scoreboard bench for memwb_elastic_reg; expectations follow the
// buffering mode selected by MEMWB_SKID_EN.
module tb_memwb_elastic_reg;
  import memwb_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush_i;
  logic                  m_valid_i;
  logic                  m_ready_o;
  logic [XLEN_DEF-1:0]   m_alu_result_i;
  logic [XLEN_DEF-1:0]   m_rdata_i;
  logic [XLEN_DEF-1:0]   m_pc4_i;
  logic [REG_AW_DEF-1:0] m_rd_i;
  logic                  m_regwrite_i;
  logic [1:0]            m_result_src_i;
  logic                  w_valid_o;
  logic                  w_ready_i;
  logic [XLEN_DEF-1:0]   w_result_o;
  logic [REG_AW_DEF-1:0] w_rd_o;
  logic                  w_regwrite_o;

  always #5 clk = ~clk;

  memwb_elastic_reg #(
    .XLEN   (XLEN_DEF),
    .REG_AW (REG_AW_DEF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush_i),
    .m_valid_i      (m_valid_i),
    .m_ready_o      (m_ready_o),
    .m_alu_result_i (m_alu_result_i),
    .m_rdata_i      (m_rdata_i),
    .m_pc4_i        (m_pc4_i),
    .m_rd_i         (m_rd_i),
    .m_regwrite_i   (m_regwrite_i),
    .m_result_src_i (m_result_src_i),
    .w_valid_o      (w_valid_o),
    .w_ready_i      (w_ready_i),
    .w_result_o     (w_result_o),
    .w_rd_o         (w_rd_o),
    .w_regwrite_o   (w_regwrite_o)
  );

  memwb_payload_t sb[$];
  memwb_payload_t cur;
  int  errors = 0;
  int  checks = 0;
  int  retires_seen = 0;
  bit  last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic memwb_payload_t mk(input logic [31:0] alu, input logic [31:0] rdata,
                                        input logic [31:0] pc4, input logic [4:0] rd,
                                        input logic rw, input logic [1:0] src);
    memwb_payload_t p;
    p.alu = alu; p.rdata = rdata; p.pc4 = pc4;
    p.rd = rd; p.regwrite = rw; p.result_src = src;
    return p;
  endfunction

  function automatic logic [31:0] exp_result(input memwb_payload_t p);
    if (p.result_src == 2'b01) return p.rdata;
    if (p.result_src == 2'b10) return p.pc4;
    return p.alu;
  endfunction

  task automatic drive(input memwb_payload_t p, input logic v);
    cur            = p;
    m_valid_i      = v;
    m_alu_result_i = p.alu;
    m_rdata_i      = p.rdata;
    m_pc4_i        = p.pc4;
    m_rd_i         = p.rd;
    m_regwrite_i   = p.regwrite;
    m_result_src_i = p.result_src;
  endtask

  // Compare outputs with the scoreboard head, then advance one clock and update the model.
  task automatic step();
    logic exp_rdy, acc, ret;
    #1;
`ifdef MEMWB_SKID_EN
    exp_rdy = (sb.size() < 2);
`else
    exp_rdy = (sb.size() == 0) || w_ready_i;
`endif
    check("m_ready", m_ready_o, exp_rdy);
    check("w_valid", w_valid_o, sb.size() > 0);
    if (sb.size() > 0) begin
      check("w_result", w_result_o, exp_result(sb[0]));
      check("w_rd", w_rd_o, sb[0].rd);
      check("w_regwrite", w_regwrite_o, sb[0].regwrite && (sb[0].rd != 0));
      if (w_valid_o && w_ready_i) retires_seen++;
    end else begin
      check("w_regwrite_idle", w_regwrite_o, 1'b0);
    end
    acc = m_valid_i && exp_rdy;
    ret = (sb.size() > 0) && w_ready_i;
    last_acc = acc;
    @(posedge clk);
    #1;
    if (flush_i) sb.delete();
    else begin
      if (ret) void'(sb.pop_front());
      if (acc) sb.push_back(cur);
    end
  endtask

  task automatic send(input memwb_payload_t p);
    bit done = 1'b0;
    drive(p, 1'b1);
    for (int n = 0; n < 20 && !done; n++) begin
      step();
      if (last_acc) done = 1'b1;
    end
    check("send_accepted", done, 1'b1);
    m_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush_i = 1'b0; w_ready_i = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0), 1'b0);
    #12;
    check("rst_w_valid", w_valid_o, 1'b0);
    check("rst_w_regwrite", w_regwrite_o, 1'b0);
    check("rst_w_result", w_result_o, 32'h0);
    check("rst_w_rd", w_rd_o, 5'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_m_ready", m_ready_o, 1'b1);

    // ALU result to a live register, then a load to x0.
    send(mk(32'h10, 32'h0, 32'h4, 5'd3, 1'b1, 2'b00));
    step(); step();
    send(mk(32'h55, 32'hDEADBEEF, 32'h8, 5'd0, 1'b1, 2'b01));
    step(); step();

    // Backpressure: two offers against a stalled WB side.
    w_ready_i = 1'b0;
`ifdef MEMWB_SKID_EN
    send(mk(32'h1, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00));
    send(mk(32'h2, 32'h0, 32'h0, 5'd2, 1'b1, 2'b11));
    step();
    check("full_m_ready", m_ready_o, 1'b0);
    step();
    w_ready_i = 1'b1;
    step(); step(); step();
`else
    send(mk(32'h1, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00));
    step();
    check("stall_m_ready", m_ready_o, 1'b0);
    w_ready_i = 1'b1;
    send(mk(32'h2, 32'h0, 32'h0, 5'd2, 1'b1, 2'b11));
    step(); step();
`endif
    check("drained_m_ready", m_ready_o, 1'b1);

    // Flush while full with a simultaneous offer.
    w_ready_i = 1'b0;
    send(mk(32'hA1, 32'h0, 32'hC, 5'd5, 1'b1, 2'b10));
`ifdef MEMWB_SKID_EN
    send(mk(32'hA2, 32'h0, 32'h10, 5'd6, 1'b1, 2'b10));
`endif
    drive(mk(32'hBAD, 32'hBAD, 32'hBAD, 5'd7, 1'b1, 2'b00), 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; m_valid_i = 1'b0;
    check("flush_w_valid", w_valid_o, 1'b0);
    w_ready_i = 1'b1;
    step(); step(); step();

    // Back-to-back stream with WB always ready.
    retires_seen = 0;
    for (int i = 0; i < 100; i++) begin
      drive(mk(i, ~i, 4 * i + 4, i[4:0], i[0], i[1:0]), 1'b1);
      step();
    end
    m_valid_i = 1'b0;
    step();
    check("stream_retires", retires_seen, 100);
    check("stream_done_valid", w_valid_o, 1'b0);

    // Asynchronous reset mid-cycle while one entry is held.
    w_ready_i = 1'b0;
    send(mk(32'h77, 32'h88, 32'h99, 5'd9, 1'b1, 2'b00));
    check("pre_arst_w_valid", w_valid_o, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_w_valid", w_valid_o, 1'b0);
    check("arst_w_regwrite", w_regwrite_o, 1'b0);
    check("arst_w_result", w_result_o, 32'h0);
    check("arst_w_rd", w_rd_o, 5'h0);
    sb.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    w_ready_i = 1'b1;
    check("post_arst_m_ready", m_ready_o, 1'b1);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
